// File: rtl/evm_pkg.sv
// Shared definitions for the EVM tally: FSM state encoding and party indices.
package evm_pkg;

  typedef enum logic [1:0] {
    ST_COUNT  = 2'd0,
    ST_SEALED = 2'd1,
    ST_READ   = 2'd2,
    ST_CLEAR  = 2'd3
  } state_t;

  localparam int NUM_PARTY = 4;

  localparam logic [1:0] PARTY1 = 2'd0;
  localparam logic [1:0] PARTY2 = 2'd1;
  localparam logic [1:0] PARTY3 = 2'd2;
  localparam logic [1:0] PARTY4 = 2'd3;

endpackage

// File: rtl/evm_sat_counter.sv
// One saturating per-party counter: increments in 1 cycle, sticks at all-ones, sync clear wins.
// o_sat is combinational from the stored count so the caller can flag overflow on the same edge.
module evm_sat_counter #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_inc,
  input  logic               i_clr,
  output logic [COUNT_W-1:0] o_cnt,
  output logic               o_sat
);

  logic [COUNT_W-1:0] r_cnt;

  assign o_sat = &r_cnt;
  assign o_cnt = r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/evm_vote_tally.sv
// Vote tally: edge-detected votes into 4 saturating counters, seal/read(1-cycle)/4-step clear FSM.
// Optional EVM_TALLY_TOTAL_EN adds a non-saturating total_votes output.
module evm_vote_tally
  import evm_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               vote_strobe,
  input  logic [1:0]         incr_party_vote,
  input  logic               seal,
  input  logic               officer_id_status,
  input  logic               read_req,
  input  logic [1:0]         read_party,
  input  logic               clear_req,
  output logic [COUNT_W-1:0] count_out,
  output logic               read_valid,
  output logic               sealed,
  output logic               overflow,
  output logic               busy
`ifdef EVM_TALLY_TOTAL_EN
  ,
  output logic [COUNT_W+1:0] total_votes
`endif
);

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_strobe_d;
  logic                   w_accept;
  logic [1:0]             r_clr_idx;
  logic [1:0]             r_rd_party;
  logic [COUNT_W-1:0]     r_count_out;
  logic                   r_read_valid;
  logic                   r_overflow;
  logic [NUM_PARTY-1:0]   w_clr_step;
  logic                   w_clr_last;
  logic [NUM_PARTY-1:0]   w_inc;
  logic [NUM_PARTY-1:0]   w_sat;
  logic [COUNT_W-1:0]     w_cnt [NUM_PARTY];

  // Only the rising edge of the strobe counts, and only while counting.
  assign w_accept = vote_strobe && !r_strobe_d && (r_state == ST_COUNT);

  for (genvar g = 0; g < NUM_PARTY; g++) begin : g_party
    assign w_inc[g] = w_accept && (incr_party_vote == 2'(g));

    evm_sat_counter #(.COUNT_W(COUNT_W)) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .i_inc   (w_inc[g]),
      .i_clr   (w_clr_step[g]),
      .o_cnt   (w_cnt[g]),
      .o_sat   (w_sat[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_COUNT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_COUNT:  if (seal) w_next = ST_SEALED;
      ST_SEALED: begin
        if (clear_req && officer_id_status) w_next = ST_CLEAR;
        else if (read_req)                  w_next = ST_READ;
      end
      ST_READ:   w_next = ST_SEALED;
      ST_CLEAR:  if (r_clr_idx == 2'd3) w_next = ST_COUNT;
      default:   w_next = ST_COUNT;
    endcase
  end

  always_comb begin
    sealed     = 1'b0;
    busy       = 1'b0;
    w_clr_step = '0;
    w_clr_last = 1'b0;
    case (r_state)
      ST_SEALED, ST_READ: sealed = 1'b1;
      ST_CLEAR: begin
        busy                  = 1'b1;
        w_clr_step[r_clr_idx] = 1'b1;
        w_clr_last            = (r_clr_idx == 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_strobe_d   <= 1'b0;
      r_clr_idx    <= 2'd0;
      r_rd_party   <= 2'd0;
      r_count_out  <= '0;
      r_read_valid <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_strobe_d   <= vote_strobe;
      r_clr_idx    <= (r_state == ST_CLEAR) ? r_clr_idx + 2'd1 : 2'd0;
      r_read_valid <= (r_state == ST_READ);
      if (r_state == ST_SEALED) r_rd_party <= read_party;
      // Counts are frozen while sealed, so reading them one cycle later is exact.
      if (r_state == ST_READ) r_count_out <= w_cnt[r_rd_party];
      if (w_clr_last) begin
        r_overflow <= 1'b0;
      end else if (w_accept && w_sat[incr_party_vote]) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign count_out  = r_count_out;
  assign read_valid = r_read_valid;
  assign overflow   = r_overflow;

`ifdef EVM_TALLY_TOTAL_EN
  logic [COUNT_W+1:0] r_total;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_total <= '0;
    end else if (w_clr_step[0]) begin
      r_total <= '0;
    end else if (w_accept) begin
      r_total <= r_total + 1'b1;
    end
  end

  assign total_votes = r_total;
`endif

endmodule
